// File: rtl/arf192b080e1r1w0cbbehbaa4acw_swt_obs_misr.sv
// Observation-flop signature compactor: MISR over a programmed cycle count, then parallel hold and serial unload.
// Optional X-masking of observation bits is enabled with ARF192B080E1R1W0CBBEHBAA4ACW_SWT_OBS_MISR_XMASK_EN.
module arf192b080e1r1w0cbbehbaa4acw_swt_obs_misr #(
    parameter int                    OBS_FLOP_NUM = 8,
    parameter int                    MISR_WIDTH   = 16,
    parameter logic [MISR_WIDTH-1:0] MISR_POLY    = 16'h100B,
    parameter int                    CNT_W        = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [OBS_FLOP_NUM-1:0] obs_in,
`ifdef ARF192B080E1R1W0CBBEHBAA4ACW_SWT_OBS_MISR_XMASK_EN
    input  logic [OBS_FLOP_NUM-1:0] obs_mask,
`endif
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_cycles,
    input  logic                    unload_req,
    input  logic                    sig_ready,
    output logic                    busy,
    output logic                    done,
    output logic [MISR_WIDTH-1:0]   signature,
    output logic                    sig_valid,
    output logic                    sig_bit
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPACT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_UNLOAD  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [MISR_WIDTH-1:0]   misr_q, misr_d;
    logic [MISR_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, done_q, sig_valid_q, sig_bit_q;
    logic [OBS_FLOP_NUM-1:0] obs_eff;
    logic [MISR_WIDTH-1:0]   feedback;

`ifdef ARF192B080E1R1W0CBBEHBAA4ACW_SWT_OBS_MISR_XMASK_EN
    assign obs_eff = obs_in & ~obs_mask;
`else
    assign obs_eff = obs_in;
`endif

    // Observation bit j lands on MISR bit (j mod MISR_WIDTH); wide buses wrap around.
    function automatic logic [MISR_WIDTH-1:0] fold(input logic [OBS_FLOP_NUM-1:0] v);
        logic [MISR_WIDTH-1:0] f;
        f = '0;
        for (int j = 0; j < OBS_FLOP_NUM; j++) begin
            f = f ^ (MISR_WIDTH'(v[j]) << (j % MISR_WIDTH));
        end
        return f;
    endfunction

    assign feedback = misr_q[MISR_WIDTH-1] ? MISR_POLY : '0;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        misr_d  = misr_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    misr_d  = '0;
                    cnt_d   = num_cycles;
                    state_d = (num_cycles == '0) ? S_DONE : S_COMPACT;
                end else if ((state_q == S_DONE) && unload_req) begin
                    shift_d = misr_q;
                    cnt_d   = CNT_W'(MISR_WIDTH);
                    state_d = S_UNLOAD;
                end
            end
            S_COMPACT: begin
                misr_d = {misr_q[MISR_WIDTH-2:0], 1'b0} ^ feedback ^ fold(obs_eff);
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_UNLOAD: begin
                if (sig_ready) begin
                    shift_d = {shift_q[MISR_WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are flopped from the next state so they line up with state_q without a decode path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            misr_q      <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sig_valid_q <= 1'b0;
            sig_bit_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            misr_q      <= misr_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d == S_COMPACT) || (state_d == S_UNLOAD);
            done_q      <= (state_d == S_DONE);
            sig_valid_q <= (state_d == S_UNLOAD);
            sig_bit_q   <= (state_d == S_UNLOAD) && shift_d[MISR_WIDTH-1];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = misr_q;
    assign sig_valid = sig_valid_q;
    assign sig_bit   = sig_bit_q;

endmodule

// File: tb/tb_arf192b080e1r1w0cbbehbaa4acw_swt_obs_misr.sv
// Self-checking bench for the observation MISR: reference model computes signatures as polynomial arithmetic.
// Exercises the mask feature when ARF192B080E1R1W0CBBEHBAA4ACW_SWT_OBS_MISR_XMASK_EN is defined.
module tb_arf192b080e1r1w0cbbehbaa4acw_swt_obs_misr;

    localparam int OBS = 8;
    localparam int W   = 16;
    localparam int CW  = 16;
    localparam logic [W-1:0] POLY = 16'h100B;

    logic          clock = 1'b0;
    logic          reset;
    logic [OBS-1:0] obs_in;
    logic [OBS-1:0] mask_v;
    logic          start;
    logic [CW-1:0] num_cycles;
    logic          unload_req;
    logic          sig_ready;
    logic          busy, done, sig_valid, sig_bit;
    logic [W-1:0]  signature;

    int n_checks = 0;
    int n_fail   = 0;
    logic [OBS-1:0] stim[$];

    always #5 clock = ~clock;

    arf192b080e1r1w0cbbehbaa4acw_swt_obs_misr dut (
        .clock      (clock),
        .reset      (reset),
        .obs_in     (obs_in),
`ifdef ARF192B080E1R1W0CBBEHBAA4ACW_SWT_OBS_MISR_XMASK_EN
        .obs_mask   (mask_v),
`endif
        .start      (start),
        .num_cycles (num_cycles),
        .unload_req (unload_req),
        .sig_ready  (sig_ready),
        .busy       (busy),
        .done       (done),
        .signature  (signature),
        .sig_valid  (sig_valid),
        .sig_bit    (sig_bit)
    );

    // Folded observation word as an integer: bit j contributes 2**(j mod W).
    function automatic int fold_ref(input logic [OBS-1:0] v);
        int acc = 0;
        for (int j = 0; j < OBS; j++) if (v[j]) acc = acc ^ (1 << (j % W));
        return acc;
    endfunction

    // Multiply the signature polynomial by x modulo P(x), then add the folded observation word.
    function automatic logic [W-1:0] step_ref(input logic [W-1:0] m, input logic [OBS-1:0] o);
        int prod = int'(m) * 2;
        if (prod >= (1 << W)) prod = (prod - (1 << W)) ^ int'(POLY);
        return W'(prod ^ fold_ref(o));
    endfunction

    task automatic chk_status(input string name, input logic [2:0] exp_bdv);
        n_checks++;
        if ({busy, done, sig_valid} !== exp_bdv) begin
            n_fail++;
            $display("FAIL %s: busy/done/sig_valid got %b expected %b @%0t", name, {busy, done, sig_valid}, exp_bdv, $time);
        end
    endtask

    task automatic chk_sig(input string name, input logic [W-1:0] exp_sig);
        n_checks++;
        if (signature !== exp_sig) begin
            n_fail++;
            $display("FAIL %s: signature got %h expected %h @%0t", name, signature, exp_sig, $time);
        end
    endtask

    // Runs one job over the stim queue; optional perturbation pulses start/unload_req mid-compaction.
    task automatic run_job(input string name, input bit perturb, input bit with_unload, output logic [W-1:0] exp_sig);
        int n = stim.size();
        logic [W-1:0] model = '0;
        @(negedge clock);
        start = 1'b1; num_cycles = CW'(n); unload_req = with_unload;
        @(negedge clock);
        start = 1'b0; unload_req = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk_status({name, " compact"}, 3'b100);
            chk_sig({name, " running"}, model);
            obs_in = stim[k];
            if (perturb && n >= 2 && k == n / 2) begin
                start = 1'b1; num_cycles = CW'($urandom_range(0, 5)); unload_req = 1'b1;
            end
            model = step_ref(model, stim[k] & ~mask_v);
            @(negedge clock);
            start = 1'b0; unload_req = 1'b0;
        end
        obs_in = OBS'($urandom);
        chk_status({name, " done"}, 3'b010);
        chk_sig({name, " final"}, model);
        exp_sig = model;
    endtask

    task automatic run_unload(input string name, input logic [W-1:0] exp_sig, input int stall_beat, input int stall_len);
        logic held;
        @(negedge clock);
        unload_req = 1'b1; sig_ready = 1'b1;
        @(negedge clock);
        unload_req = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == stall_beat) begin
                sig_ready = 1'b0;
                held = sig_bit;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clock);
                    chk_status({name, " stalled"}, 3'b101);
                    n_checks++;
                    if (sig_bit !== held) begin
                        n_fail++;
                        $display("FAIL %s stall: sig_bit got %b expected %b", name, sig_bit, held);
                    end
                end
                sig_ready = 1'b1;
            end
            chk_status({name, " beat"}, 3'b101);
            n_checks++;
            if (sig_bit !== exp_sig[W-1-i]) begin
                n_fail++;
                $display("FAIL %s beat %0d: sig_bit got %b expected %b", name, i, sig_bit, exp_sig[W-1-i]);
            end
            @(negedge clock);
        end
        chk_status({name, " idle after"}, 3'b000);
        chk_sig({name, " sig retained"}, exp_sig);
        n_checks++;
        if (sig_bit !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: sig_bit in idle got %b expected 0", name, sig_bit);
        end
        unload_req = 1'b1;
        @(negedge clock);
        unload_req = 1'b0;
        chk_status({name, " unload ignored in idle"}, 3'b000);
    endtask

    task automatic test_reset();
        logic [W-1:0] tmp;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_status("reset", 3'b000);
        chk_sig("reset", '0);
        reset = 1'b0;
        @(negedge clock);
        chk_status("post reset", 3'b000);
        // Abort mid-compaction with N=16.
        @(negedge clock);
        start = 1'b1; num_cycles = CW'(16);
        @(negedge clock);
        start = 1'b0;
        repeat (5) begin
            obs_in = OBS'($urandom_range(1, 255));
            @(negedge clock);
        end
        chk_status("mid compact busy", 3'b100);
        reset = 1'b1;
        #1;
        chk_status("async abort", 3'b000);
        chk_sig("async abort", '0);
        @(negedge clock);
        chk_status("abort next cycle", 3'b000);
        chk_sig("abort next cycle", '0);
        reset = 1'b0;
        @(negedge clock);
        chk_status("abort idle", 3'b000);
        stim = {};
        run_job("zero after abort", 1'b0, 1'b0, tmp);
    endtask

    task automatic test_single();
        logic [W-1:0] s;
        stim = {8'h01};
        run_job("single", 1'b0, 1'b0, s);
        chk_sig("single const", 16'h0001);
    endtask

    task automatic test_zero();
        logic [W-1:0] s;
        stim = {};
        run_job("zero", 1'b0, 1'b0, s);
        chk_sig("zero const", 16'h0000);
    endtask

    task automatic test_poly();
        logic [W-1:0] s;
        stim = {8'h01};
        for (int i = 0; i < 15; i++) stim.push_back(8'h00);
        run_job("poly16", 1'b0, 1'b0, s);
        chk_sig("poly16 const", 16'h8000);
        stim.push_back(8'h00);
        run_job("poly17", 1'b0, 1'b0, s);
        chk_sig("poly17 const", 16'h100B);
        run_unload("unload 100B", 16'h100B, 4, 3);
    endtask

    task automatic test_random();
        logic [W-1:0] s;
        for (int r = 0; r < 8; r++) begin
            stim = {};
            for (int k = 0; k < int'($urandom_range(1, 40)); k++) stim.push_back(OBS'($urandom));
            run_job("random", 1'b1, 1'b0, s);
            if (r % 2 == 1) run_unload("random unload", s, int'($urandom_range(0, W - 1)), int'($urandom_range(1, 4)));
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] s;
        stim = {8'hA5, 8'h3C, 8'hFF};
        run_job("b2b first", 1'b0, 1'b0, s);
        stim = {8'h80, 8'h01};
        run_job("b2b start over unload", 1'b0, 1'b1, s);
        stim = {};
        run_job("b2b zero from done", 1'b0, 1'b0, s);
    endtask

`ifdef ARF192B080E1R1W0CBBEHBAA4ACW_SWT_OBS_MISR_XMASK_EN
    task automatic test_mask();
        logic [W-1:0] s;
        mask_v = 8'hF0;
        stim = {8'hFF};
        run_job("mask", 1'b0, 1'b0, s);
        chk_sig("mask const", 16'h000F);
        mask_v = OBS'($urandom);
        stim = {};
        for (int k = 0; k < 10; k++) stim.push_back(OBS'($urandom));
        run_job("mask random", 1'b0, 1'b0, s);
        mask_v = '0;
    endtask
`endif

    initial begin
        reset = 1'b1; obs_in = '0; mask_v = '0; start = 1'b0;
        num_cycles = '0; unload_req = 1'b0; sig_ready = 1'b1;
        test_reset();
        test_single();
        test_zero();
        test_poly();
        test_random();
        test_back_to_back();
`ifdef ARF192B080E1R1W0CBBEHBAA4ACW_SWT_OBS_MISR_XMASK_EN
        test_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arf192b080e1r1w0cbbehbaa4acw_swt_obs_misr.md
# arf192b080e1r1w0cbbehbaa4acw_swt_obs_misr

Signature compactor that sits directly downstream of the SWT observation flop bank. It folds the registered observation bits into a multiple-input signature register (MISR) for a programmed number of cycles, then holds the signature for parallel read and unloads it serially over a valid/ready handshake. This gives BIST and ATE flows a single signature check in place of a per-cycle compare of every observation flop.

## Interface
- OBS_FLOP_NUM, 8, width of the observation bus from the observation flop bank
- MISR_WIDTH, 16, signature width (>= 2)
- MISR_POLY, 16'h100B, feedback taps (x^16+x^12+x^3+x+1); bit k set means feedback is XORed into bit k
- CNT_W, 16, width of the cycle-count input
- clock  input  1  array port clock, same clock as the observation flops
- reset  input  1  asynchronous, active-high reset
- obs_in  input  OBS_FLOP_NUM  registered observation flop outputs
- start  input  1  single-cycle start request
- num_cycles  input  CNT_W  number of compaction cycles, sampled with start
- unload_req  input  1  request serial unload, honoured only in DONE
- sig_ready  input  1  consumer accepts sig_bit
- busy  output  1  high in COMPACT or UNLOAD
- done  output  1  high in DONE
- signature  output  MISR_WIDTH  current MISR contents
- sig_valid  output  1  sig_bit is valid (UNLOAD only)
- sig_bit  output  1  serial signature bit, MSB first

## Operation
- States: IDLE, COMPACT, DONE, UNLOAD. Reset puts the block in IDLE with MISR=0, counter=0, busy=0, done=0, sig_valid=0 and sig_bit=0.
- IDLE or DONE, start=1: MISR cleared to 0 and num_cycles latched. If num_cycles==0, go to DONE. Otherwise go to COMPACT.
- COMPACT: each cycle, misr <= {misr[W-2:0],1'b0} ^ (misr[W-1] ? MISR_POLY : 0) ^ fold(obs_in).
  - fold: bit j of obs_in is XORed into MISR bit (j mod MISR_WIDTH).
  - The counter decrements each cycle. The transition to DONE happens after exactly num_cycles updates.
- DONE: signature is held stable. start has priority over unload_req. unload_req=1 loads the shift register from the MISR and goes to UNLOAD.
- UNLOAD:
  - sig_valid=1 and sig_bit = shift MSB.
  - A beat transfers when sig_valid && sig_ready, then the register shifts left.
  - After MISR_WIDTH transfers, go to IDLE.
  - sig_bit is held while sig_ready=0.
  - The MISR is not modified, so signature still reads the final value.
- start during COMPACT or UNLOAD is ignored. unload_req outside DONE is ignored.
- Asserting reset mid-operation aborts immediately, with no partial signature retained.

## Timing
- Start accepted at cycle t. obs_in is sampled on cycles t+1 … t+N, where N=num_cycles.
- done rises at t+N+1. With N=0, done rises at t+1 and signature=0.
- busy is high from t+1 through t+N. done and busy are never high together.
- Unload: sig_valid rises the cycle after unload_req is accepted. Minimum unload length is MISR_WIDTH cycles with sig_ready tied high. busy is high throughout.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- Macro ARF192B080E1R1W0CBBEHBAA4ACW_SWT_OBS_MISR_XMASK_EN.
- Defined: adds input obs_mask [OBS_FLOP_NUM-1:0]. fold uses obs_in & ~obs_mask, so masked bits (known-X sources) never reach the MISR.
- Undefined: the port is absent and all bits are compacted.

## Test plan
- Reset check: assert reset mid-COMPACT, with default parameters and N=16 → next cycle busy=0, done=0, signature=16'h0000; state returns to IDLE.
- Single cycle: N=1 with obs_in=8'h01 → done at t+2, signature=16'h0001.
- Polynomial feedback: N=17, obs_in=8'h01 on first sampled cycle only, 0 thereafter → signature after 16 updates is 16'h8000; final signature is 16'h100B.
- Zero count: N=0 → done at t+1, signature=16'h0000, no obs_in sampled.
- Serial unload: from DONE with signature 16'h100B, unload_req, with sig_ready low for 3 cycles on beat 5 → accepted bits are 0,0,0,1,0,0,0,0,0,0,0,0,1,0,1,1. sig_bit is stable while stalled. IDLE follows after 16 accepts.
- Mask build (macro defined): N=1, obs_in=8'hFF, obs_mask=8'hF0 → signature=16'h000F.
